// File: rtl/fp16_vec_pkg.sv
// Shared FP16 vector types and helpers for the lane packer and its bench.
package fp16_vec_pkg;
  localparam int FP16_W = 16;

  typedef logic [FP16_W-1:0] fp16_t;

  localparam fp16_t FP16_QNAN = 16'h7E00;

  // Mask with the low n bits set; callers size-cast it down to their lane count.
  function automatic logic [7:0] lane_mask_from_count(input int n);
    return 8'((1 << n) - 1);
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through FIFO; pointers carry one extra wrap bit for full/empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_wr_ptr - r_rd_ptr;
  assign dout      = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/fp16_lane_packer.sv
// Packs the converter's FP16 result stream into LANES-wide words with a lane mask,
// buffering completed words in a small FIFO and flagging dropped words sticky-wise.
module fp16_lane_packer
  import fp16_vec_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  fp16_t                       data_i,
  input  logic                        input_valid,
  input  logic                        flush_i,
  input  logic                        out_ready,
  output logic [LANES*FP16_W-1:0]     data_o,
  output logic [LANES-1:0]            lane_mask_o,
  output logic                        out_valid,
  output logic                        overflow_o,
  output logic [$clog2(DEPTH):0]      fill_o
);
  localparam int IDX_W  = $clog2(LANES);
  localparam int WORD_W = LANES * FP16_W;
  localparam int FIFO_W = WORD_W + LANES;

  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_asm;
  logic              r_overflow;

  logic [WORD_W-1:0] w_word;
  logic [IDX_W:0]    w_cnt;
  logic [LANES-1:0]  w_mask;
  logic              w_complete;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [FIFO_W-1:0] w_fifo_dout;

  // Word as it would look after this cycle's input lands in lane idx.
  always_comb begin
    w_word = r_asm;
    for (int k = 0; k < LANES; k++) begin
      if (input_valid && (r_idx == IDX_W'(k))) w_word[k*FP16_W +: FP16_W] = data_i;
    end
  end

  assign w_cnt      = {1'b0, r_idx} + {{IDX_W{1'b0}}, input_valid};
  assign w_mask     = LANES'(lane_mask_from_count(int'(w_cnt)));
  assign w_complete = (input_valid && (r_idx == IDX_W'(LANES-1))) ||
                      (flush_i && (w_cnt != '0));
  assign w_pop      = out_valid && out_ready;

  sync_fifo_fwft #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_complete),
    .pop   (w_pop),
    .din   ({w_mask, w_word}),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .full  (w_full),
    .count (fill_o)
  );

  assign out_valid   = !w_empty;
  assign data_o      = w_fifo_dout[WORD_W-1:0];
  assign lane_mask_o = w_fifo_dout[FIFO_W-1 -: LANES];
  assign overflow_o  = r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_asm      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_complete) begin
        r_idx <= '0;
        r_asm <= '0;
      end else if (input_valid) begin
        r_idx <= r_idx + 1'b1;
        r_asm <= w_word;
      end
      if (w_complete && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end
endmodule
